// File: rtl/dmem_responder.sv
// Multi-cycle data memory for the MIPS MEM stage: request/busy/done handshake with
// LATENCY wait cycles; the array is touched only on the edge that enters DONE.
module dmem_responder #(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2      // legal range 0..7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0]  LAT     = 3'(LATENCY);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam bit          DIRECT  = (LATENCY == 0);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic        we_reg;
    logic [31:0] addr_reg, wdata_reg;
    logic        err_reg;
    logic [31:0] rdata_reg;

    logic [31:0] mem [DEPTH];

    logic        accept;
    logic        access;
    logic        acc_we;
    logic [31:0] acc_addr, acc_wdata;
    logic        acc_valid;
    logic [AW-1:0] acc_idx;

    assign accept = req && (state_reg == IDLE || state_reg == DONE);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        access     = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (accept) begin
                    if (DIRECT) begin
                        state_next = DONE;
                        access     = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = LAT;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (cnt_reg <= 3'd1) begin
                    state_next = DONE;
                    cnt_next   = 3'd0;
                    access     = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // With zero latency the access happens on the accept edge, so the live inputs are used.
    assign acc_we    = DIRECT ? we    : we_reg;
    assign acc_addr  = DIRECT ? addr  : addr_reg;
    assign acc_wdata = DIRECT ? wdata : wdata_reg;
    assign acc_valid = (acc_addr[1:0] == 2'b00) && ({2'b00, acc_addr[31:2]} < DEPTH_W);
    assign acc_idx   = acc_addr[AW+1:2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 3'd0;
            we_reg    <= 1'b0;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                we_reg    <= we;
                addr_reg  <= addr;
                wdata_reg <= wdata;
            end
        end
    end

    // Array is not reset; the rst term keeps a zero-latency store from landing while held in reset.
    always_ff @(posedge clk) begin
        if (rst && access && acc_valid && acc_we)
            mem[acc_idx] <= acc_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_reg   <= 1'b0;
            rdata_reg <= 32'd0;
        end else if (access) begin
            err_reg   <= !acc_valid;
            rdata_reg <= (acc_valid && !acc_we) ? mem[acc_idx] : 32'd0;
        end else begin
            err_reg   <= 1'b0;
            rdata_reg <= 32'd0;
        end
    end

    assign busy  = (state_reg == WAIT);
    assign done  = (state_reg == DONE);
    assign err   = err_reg;
    assign rdata = rdata_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: three responders (LATENCY 2, 0, 3) driven with directed and random
// transactions, checked against a transaction-level memory model.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  req, we, busy, done, err;
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];

    int checks = 0;
    int errors = 0;
    int lat [3] = '{2, 0, 3};
    logic [31:0] model [3][128];

    dmem_responder #(.DEPTH(128), .LATENCY(2)) u0 (
        .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0]), .rdata(rdata[0]));
    dmem_responder #(.DEPTH(128), .LATENCY(0)) u1 (
        .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1]), .rdata(rdata[1]));
    dmem_responder #(.DEPTH(128), .LATENCY(3)) u2 (
        .clk(clk), .rst(rst), .req(req[2]), .we(we[2]), .addr(addr[2]), .wdata(wdata[2]),
        .busy(busy[2]), .done(done[2]), .err(err[2]), .rdata(rdata[2]));

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_bad(logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= 30'd128);
    endfunction

    // Issues one request from a negedge and returns at the negedge inside its DONE cycle.
    task automatic txn(int k, logic w, logic [31:0] a, logic [31:0] d, bit inject);
        logic        exp_err;
        logic [31:0] exp_rd;
        req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
        @(posedge clk);
        @(negedge clk);
        req[k] = 1'b0; we[k] = 1'($urandom); addr[k] = $urandom; wdata[k] = $urandom;
        for (int i = 0; i < lat[k]; i++) begin
            chk("wait_busy", 32'(busy[k]), 32'd1);
            chk("wait_done", 32'(done[k]), 32'd0);
            if (inject && i == 0) begin
                req[k] = 1'b1; we[k] = 1'b1; addr[k] = 32'd12; wdata[k] = 32'hBAD0BAD0;
            end
            if (inject && i == 1) req[k] = 1'b0;
            @(negedge clk);
        end
        exp_err = is_bad(a);
        exp_rd  = (!exp_err && !w) ? model[k][a[8:2]] : 32'd0;
        chk("resp_done", 32'(done[k]), 32'd1);
        chk("resp_busy", 32'(busy[k]), 32'd0);
        chk("resp_err", 32'(err[k]), 32'(exp_err));
        chk("resp_rdata", rdata[k], exp_rd);
        if (!exp_err && w) model[k][a[8:2]] = d;
        $display("txn dut%0d we=%0d addr=%h wdata=%h err=%0d rdata=%h", k, w, a, d, err[k], rdata[k]);
    endtask

    task automatic idle(int k);
        @(negedge clk);
        chk("idle_done", 32'(done[k]), 32'd0);
        chk("idle_busy", 32'(busy[k]), 32'd0);
        chk("idle_err", 32'(err[k]), 32'd0);
        chk("idle_rdata", rdata[k], 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        int r;
        rst = 1'b0; req = '0; we = '0;
        for (int k = 0; k < 3; k++) begin
            addr[k] = '0; wdata[k] = '0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_busy", 32'(busy[k]), 32'd0);
            chk("rst_done", 32'(done[k]), 32'd0);
            chk("rst_err", 32'(err[k]), 32'd0);
            chk("rst_rdata", rdata[k], 32'd0);
        end
        rst = 1'b1;

        // Fill every word back-to-back, then the directed preload values.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 128; i++) txn(k, 1'b1, 32'(i * 4), $urandom, 1'b0);
            txn(k, 1'b1, 32'd0, 32'd9, 1'b0);
            txn(k, 1'b1, 32'd4, 32'd3, 1'b0);
            txn(k, 1'b1, 32'd8, 32'd15, 1'b0);
            idle(k);
        end

        txn(0, 1'b0, 32'd4, 32'd0, 1'b0);
        chk("load_w1", rdata[0], 32'd3);
        idle(0);
        txn(0, 1'b0, 32'd8, 32'd0, 1'b0);
        chk("load_w2", rdata[0], 32'd15);
        idle(0);

        txn(0, 1'b1, 32'd20, 32'hDEADBEEF, 1'b0);
        txn(0, 1'b0, 32'd20, 32'd0, 1'b0);
        chk("st_ld_fwd", rdata[0], 32'hDEADBEEF);
        idle(0);

        txn(0, 1'b0, 32'd5, 32'd0, 1'b0);
        chk("misalign_err", 32'(err[0]), 32'd1);
        idle(0);
        txn(0, 1'b1, 32'd512, 32'h55555555, 1'b0);
        chk("range_err", 32'(err[0]), 32'd1);
        for (int i = 0; i < 128; i++) txn(0, 1'b0, 32'(i * 4), 32'd0, 1'b0);
        idle(0);

        // Reset during WAIT drops the pending store.
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'd0; wdata[0] = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req[0] = 1'b0;
        chk("pre_rst_busy", 32'(busy[0]), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy[0]), 32'd0);
        chk("mid_rst_done", 32'(done[0]), 32'd0);
        chk("mid_rst_err", 32'(err[0]), 32'd0);
        chk("mid_rst_rdata", rdata[0], 32'd0);
        @(negedge clk);
        rst = 1'b1;
        txn(0, 1'b0, 32'd0, 32'd0, 1'b0);
        chk("after_rst_w0", rdata[0], 32'd9);
        idle(0);

        txn(1, 1'b0, 32'd0, 32'd0, 1'b0);
        chk("lat0_a", rdata[1], 32'd9);
        txn(1, 1'b0, 32'd4, 32'd0, 1'b0);
        chk("lat0_b", rdata[1], 32'd3);
        txn(1, 1'b0, 32'd8, 32'd0, 1'b0);
        chk("lat0_c", rdata[1], 32'd15);
        idle(1);

        // A store pulsed during WAIT must be ignored entirely.
        txn(2, 1'b0, 32'd4, 32'd0, 1'b1);
        idle(2);
        idle(2);
        txn(2, 1'b0, 32'd12, 32'd0, 1'b0);
        idle(2);

        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 60; n++) begin
                r = int'($urandom_range(0, 9));
                if (r < 7)       a = 32'($urandom_range(0, 127)) << 2;
                else if (r == 7) a = (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(1, 3));
                else             a = 32'h0000_0200 | ($urandom & 32'hFFFF_FFFC);
                txn(k, 1'($urandom_range(0, 1)), a, $urandom, 1'b0);
                if ($urandom_range(0, 2) == 0) idle(k);
            end
            idle(k);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
